// File: rtl/project_triangle_to_viewport.sv
// Projects NUM_VERTS camera-relative vertices to viewport space and culls; one primitive per handshake.
// Latency NUM_VERTS*(DIV_STEPS+2) cycles (less on near-plane cull); ready_out only in IDLE, result held until ready_in.
module project_triangle_to_viewport #(
   parameter int C_WIDTH     = 18,
   parameter int P_WIDTH     = 16,
   parameter int V_WIDTH     = 16,
   parameter int FRAC_BITS   = 14,
   parameter int NUM_VERTS   = 3,
   parameter int VP_WIDTH    = 18,
   parameter int VW_OVER_TWO = 16384,
   parameter int VH_OVER_TWO = 16384,
   parameter int NEAR        = 1,
   parameter int CULL_MODE   = 0,
   parameter int EMIT_CULLED = 1
) (
   input  logic                               clk_in,
   input  logic                               rst_n_in,
   input  logic                               valid_in,
   output logic                               ready_out,
   input  logic [NUM_VERTS*3*P_WIDTH-1:0]     P,
   input  logic [3*C_WIDTH-1:0]               C,
   input  logic [3*V_WIDTH-1:0]               u,
   input  logic [3*V_WIDTH-1:0]               v,
   input  logic [3*V_WIDTH-1:0]               n,
   output logic                               valid_out,
   input  logic                               ready_in,
   output logic [NUM_VERTS*VP_WIDTH-1:0]      vp_x,
   output logic [NUM_VERTS*VP_WIDTH-1:0]      vp_y,
   output logic [NUM_VERTS*(C_WIDTH+1)-1:0]   z_depth,
   output logic [NUM_VERTS-1:0]               in_view,
   output logic                               culled
);
   localparam int DOT_W     = C_WIDTH + V_WIDTH - FRAC_BITS + 3;
   localparam int PROD_W    = DOT_W + FRAC_BITS;
   localparam int DIV_STEPS = DOT_W + FRAC_BITS;
   localparam int ZW        = C_WIDTH + 1;
   localparam int IDX_W     = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;
   localparam int CNT_W     = $clog2(DIV_STEPS + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] DOT   = 3'd1;
   localparam logic [2:0] DIV   = 3'd2;
   localparam logic [2:0] CHECK = 3'd3;
   localparam logic [2:0] OUT   = 3'd4;

   localparam logic [CNT_W-1:0]           LAST_STEP = CNT_W'(DIV_STEPS - 1);
   localparam logic [IDX_W-1:0]           LAST_IDX  = IDX_W'(NUM_VERTS - 1);
   localparam logic signed [DOT_W-1:0]    NEAR_S    = DOT_W'(NEAR);
   localparam logic signed [VP_WIDTH-1:0] VW_P      = VP_WIDTH'(VW_OVER_TWO);
   localparam logic signed [VP_WIDTH-1:0] VH_P      = VP_WIDTH'(VH_OVER_TWO);
   localparam logic [PROD_W-1:0] HALF = {{(PROD_W-VP_WIDTH){1'b0}}, 1'b1, {(VP_WIDTH-1){1'b0}}};

   logic [2:0]                     state;
   logic [IDX_W-1:0]               idx;
   logic [CNT_W-1:0]               cnt;
   logic [NUM_VERTS*3*P_WIDTH-1:0] p_r;
   logic [3*C_WIDTH-1:0]           c_r;
   logic [3*V_WIDTH-1:0]           u_r, v_r, n_r;
   logic [DOT_W-1:0]               den_r;
   logic [PROD_W-1:0]              numx, numy;
   logic [DOT_W-1:0]               remx, remy;
   logic                           negx, negy;

   function automatic logic signed [PROD_W-1:0] ext_c(input logic [C_WIDTH:0] a);
      return {{(PROD_W-C_WIDTH-1){a[C_WIDTH]}}, a};
   endfunction

   function automatic logic signed [PROD_W-1:0] ext_v(input logic [V_WIDTH-1:0] b);
      return {{(PROD_W-V_WIDTH){b[V_WIDTH-1]}}, b};
   endfunction

   function automatic logic signed [DOT_W-1:0] dot3(input logic [C_WIDTH:0] a0, a1, a2,
                                                    input logic [3*V_WIDTH-1:0] b);
      logic signed [PROD_W-1:0] acc, sh;
      acc = ext_c(a0) * ext_v(b[0 +: V_WIDTH]) + ext_c(a1) * ext_v(b[V_WIDTH +: V_WIDTH])
          + ext_c(a2) * ext_v(b[2*V_WIDTH +: V_WIDTH]);
      sh = acc >>> FRAC_BITS;
      return sh[DOT_W-1:0];
   endfunction

   function automatic logic [DOT_W-1:0] abs_d(input logic signed [DOT_W-1:0] d);
      return d[DOT_W-1] ? -d : d;
   endfunction

   // Quotient is a magnitude; clamp it into the signed output range before applying the sign.
   function automatic logic [VP_WIDTH-1:0] sat(input logic [PROD_W-1:0] q, input logic neg);
      if (!neg) return (q >= HALF) ? {1'b0, {(VP_WIDTH-1){1'b1}}} : q[VP_WIDTH-1:0];
      else      return (q >= HALF) ? {1'b1, {(VP_WIDTH-1){1'b0}}} : -q[VP_WIDTH-1:0];
   endfunction

   logic [31:0]                idx_w;
   logic [3*P_WIDTH-1:0]       p_sel;
   logic [C_WIDTH:0]           pc [3];
   logic signed [DOT_W-1:0]    du, dv, dn;
   logic [DOT_W:0]             rx_sh, ry_sh, den_x;
   logic                       qx, qy;
   logic signed [VP_WIDTH-1:0] sx, sy;
   logic                       iv;
   logic [NUM_VERTS-1:0]       iv_all;
   logic                       cull_eval;

   assign idx_w = 32'(idx);
   assign p_sel = p_r[idx_w*(3*P_WIDTH) +: 3*P_WIDTH];

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         pc[k] = {{(C_WIDTH+1-P_WIDTH){p_sel[k*P_WIDTH+P_WIDTH-1]}}, p_sel[k*P_WIDTH +: P_WIDTH]}
               - {c_r[k*C_WIDTH+C_WIDTH-1], c_r[k*C_WIDTH +: C_WIDTH]};
      end
      du = dot3(pc[0], pc[1], pc[2], u_r);
      dv = dot3(pc[0], pc[1], pc[2], v_r);
      dn = dot3(pc[0], pc[1], pc[2], n_r);
   end

   always_comb begin
      den_x = {1'b0, den_r};
      rx_sh = {remx, numx[PROD_W-1]};
      ry_sh = {remy, numy[PROD_W-1]};
      qx    = (rx_sh >= den_x);
      qy    = (ry_sh >= den_x);
      sx    = sat(numx, negx);
      sy    = sat(numy, negy);
      iv    = (sx > -VW_P) && (sx < VW_P) && (sy > -VH_P) && (sy < VH_P);
      iv_all      = in_view;
      iv_all[idx] = iv;
      cull_eval   = (CULL_MODE == 0) ? ~&iv_all : ~|iv_all;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE; idx <= '0; cnt <= '0;
         p_r <= '0; c_r <= '0; u_r <= '0; v_r <= '0; n_r <= '0;
         den_r <= '0; numx <= '0; numy <= '0; remx <= '0; remy <= '0;
         negx <= 1'b0; negy <= 1'b0;
         ready_out <= 1'b0; valid_out <= 1'b0;
         vp_x <= '0; vp_y <= '0; z_depth <= '0; in_view <= '0; culled <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_in && ready_out) begin
                  p_r <= P; c_r <= C; u_r <= u; v_r <= v; n_r <= n;
                  vp_x <= '0; vp_y <= '0; z_depth <= '0; in_view <= '0; culled <= 1'b0;
                  idx <= '0; ready_out <= 1'b0; state <= DOT;
               end else begin
                  ready_out <= 1'b1;
               end
            end
            DOT: begin
               if (dn < NEAR_S) begin
                  // Behind the near plane: reject the whole primitive without dividing.
                  z_depth[idx_w*ZW +: ZW] <= dn[C_WIDTH:0];
                  culled <= 1'b1;
                  if (EMIT_CULLED != 0) begin state <= OUT;  valid_out <= 1'b1; end
                  else                  begin state <= IDLE; ready_out <= 1'b1; end
               end else begin
                  numx <= {abs_d(du), {FRAC_BITS{1'b0}}};
                  numy <= {abs_d(dv), {FRAC_BITS{1'b0}}};
                  remx <= '0; remy <= '0;
                  negx <= du[DOT_W-1]; negy <= dv[DOT_W-1];
                  den_r <= dn; cnt <= '0; state <= DIV;
               end
            end
            DIV: begin
               numx <= {numx[PROD_W-2:0], qx};
               numy <= {numy[PROD_W-2:0], qy};
               remx <= qx ? DOT_W'(rx_sh - den_x) : rx_sh[DOT_W-1:0];
               remy <= qy ? DOT_W'(ry_sh - den_x) : ry_sh[DOT_W-1:0];
               cnt  <= cnt + 1'b1;
               if (cnt == LAST_STEP) state <= CHECK;
            end
            CHECK: begin
               vp_x[idx_w*VP_WIDTH +: VP_WIDTH] <= sx;
               vp_y[idx_w*VP_WIDTH +: VP_WIDTH] <= sy;
               z_depth[idx_w*ZW +: ZW]          <= den_r[C_WIDTH:0];
               in_view <= iv_all;
               if (idx == LAST_IDX) begin
                  culled <= cull_eval;
                  if (cull_eval && EMIT_CULLED == 0) begin state <= IDLE; ready_out <= 1'b1; end
                  else                               begin state <= OUT;  valid_out <= 1'b1; end
               end else begin
                  idx <= idx + 1'b1; state <= DOT;
               end
            end
            OUT: begin
               if (ready_in) begin
                  valid_out <= 1'b0; ready_out <= 1'b1; state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_project_triangle_to_viewport.sv
// Directed bench: three instances (default, drop culled, cull-only-if-all) driven in lockstep.
module tb_project_triangle_to_viewport;
   localparam int VPW = 18;
   localparam int ZW  = 19;

   logic clk_in = 1'b0;
   logic rst_n_in, valid_in, ready_in;
   logic [3*3*16-1:0] P;
   logic [3*18-1:0]   C;
   logic [3*16-1:0]   u, v, n;

   logic a_ready_out, a_valid_out, a_culled, b_ready_out, b_valid_out, b_culled;
   logic c_ready_out, c_valid_out, c_culled;
   logic [3*VPW-1:0] a_vp_x, a_vp_y, b_vp_x, b_vp_y, c_vp_x, c_vp_y;
   logic [3*ZW-1:0]  a_z, b_z, c_z;
   logic [2:0]       a_iv, b_iv, c_iv;

   int errors = 0;
   int checks = 0;
   int cyc;

   always #5 clk_in = ~clk_in;

   project_triangle_to_viewport dut_a (.clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in),
      .ready_out(a_ready_out), .P(P), .C(C), .u(u), .v(v), .n(n), .valid_out(a_valid_out),
      .ready_in(ready_in), .vp_x(a_vp_x), .vp_y(a_vp_y), .z_depth(a_z), .in_view(a_iv), .culled(a_culled));
   project_triangle_to_viewport #(.EMIT_CULLED(0)) dut_b (.clk_in(clk_in), .rst_n_in(rst_n_in),
      .valid_in(valid_in), .ready_out(b_ready_out), .P(P), .C(C), .u(u), .v(v), .n(n),
      .valid_out(b_valid_out), .ready_in(ready_in), .vp_x(b_vp_x), .vp_y(b_vp_y), .z_depth(b_z),
      .in_view(b_iv), .culled(b_culled));
   project_triangle_to_viewport #(.CULL_MODE(1)) dut_c (.clk_in(clk_in), .rst_n_in(rst_n_in),
      .valid_in(valid_in), .ready_out(c_ready_out), .P(P), .C(C), .u(u), .v(v), .n(n),
      .valid_out(c_valid_out), .ready_in(ready_in), .vp_x(c_vp_x), .vp_y(c_vp_y), .z_depth(c_z),
      .in_view(c_iv), .culled(c_culled));

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint gv(input logic [3*VPW-1:0] bus, input int i);
      return longint'($signed(bus[i*VPW +: VPW]));
   endfunction

   function automatic longint gz(input logic [3*ZW-1:0] bus, input int i);
      return longint'(bus[i*ZW +: ZW]);
   endfunction

   task automatic set_vert(input int i, input int x, input int y, input int z);
      P[i*48 +: 16]      = 16'(x);
      P[i*48 + 16 +: 16] = 16'(y);
      P[i*48 + 32 +: 16] = 16'(z);
   endtask

   task automatic load_a();
      set_vert(0, 100, 50, 200); set_vert(1, 0, 0, 100); set_vert(2, -40, 20, 80);
   endtask

   task automatic load_x();
      set_vert(0, -100, -50, 200); set_vert(1, 40, -20, 80); set_vert(2, 0, 0, 100);
   endtask

   task automatic send();
      int t = 0;
      while (!a_ready_out && t < 50) begin @(negedge clk_in); t++; end
      chk("send_ready", a_ready_out, 1);
      valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      chk("busy_ready", a_ready_out, 0);
   endtask

   task automatic wait_out(output int c);
      c = 0;
      while (!a_valid_out && c < 300) begin @(negedge clk_in); c++; end
   endtask

   task automatic chk_prim(input string tag, input int x0, x1, x2, y0, y1, y2,
                           input int z0, z1, z2, input int iv, input int cul);
      chk({tag, "_vx0"}, gv(a_vp_x, 0), x0); chk({tag, "_vx1"}, gv(a_vp_x, 1), x1);
      chk({tag, "_vx2"}, gv(a_vp_x, 2), x2); chk({tag, "_vy0"}, gv(a_vp_y, 0), y0);
      chk({tag, "_vy1"}, gv(a_vp_y, 1), y1); chk({tag, "_vy2"}, gv(a_vp_y, 2), y2);
      chk({tag, "_z0"}, gz(a_z, 0), z0);     chk({tag, "_z1"}, gz(a_z, 1), z1);
      chk({tag, "_z2"}, gz(a_z, 2), z2);
      chk({tag, "_inview"}, a_iv, iv);       chk({tag, "_culled"}, a_culled, cul);
   endtask

   task automatic release_out(input string tag);
      ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      chk({tag, "_xfer_valid"}, a_valid_out, 0);
      chk({tag, "_xfer_ready"}, a_ready_out, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
      P = '0; C = '0;
      u = {16'd0, 16'd0, 16'd16384};
      v = {16'd0, 16'd16384, 16'd0};
      n = {16'd16384, 16'd0, 16'd0};

      // Reset state and ready rising on the first edge after release
      @(negedge clk_in); @(negedge clk_in);
      chk("rst_valid", a_valid_out, 0); chk("rst_ready", a_ready_out, 0);
      chk("rst_culled", a_culled, 0);   chk("rst_vpx", a_vp_x, 0);
      chk("rst_z", a_z, 0);             chk("rst_inview", a_iv, 0);
      rst_n_in = 1'b1;
      chk("rel_ready_before_edge", a_ready_out, 0);
      @(negedge clk_in);
      chk("rel_ready_after_edge", a_ready_out, 1);

      // Basic primitive, all in view, then a 20-cycle output stall
      load_a();
      send();
      wait_out(cyc);
      chk("a_latency", cyc, 117);
      chk_prim("a", 8192, 0, -8192, 4096, 0, 4096, 200, 100, 80, 7, 0);
      chk("a_b_valid", b_valid_out, 1);
      chk("a_c_culled", c_culled, 0);
      repeat (20) @(negedge clk_in);
      chk("stall_valid", a_valid_out, 1);
      chk("stall_ready", a_ready_out, 0);
      chk_prim("stall", 8192, 0, -8192, 4096, 0, 4096, 200, 100, 80, 7, 0);
      release_out("a");

      // Vertex 1 behind the near plane: early cull
      load_a(); set_vert(1, 0, 0, -5);
      send();
      wait_out(cyc);
      chk("near_latency", cyc, 40);
      chk_prim("near", 8192, 0, 0, 4096, 0, 0, 200, 524283, 0, 1, 1);
      chk("near_b_valid", b_valid_out, 0);
      chk("near_b_ready", b_ready_out, 1);
      chk("near_c_culled", c_culled, 1);
      release_out("near");

      // Vertex 0 off-screen: cull mode decides
      load_a(); set_vert(0, 300, 0, 200);
      send();
      wait_out(cyc);
      chk("vp_latency", cyc, 117);
      chk_prim("vp", 24576, 0, -8192, 0, 0, 4096, 200, 100, 80, 6, 1);
      chk("vp_b_valid", b_valid_out, 0);
      chk("vp_b_ready", b_ready_out, 1);
      chk("vp_c_valid", c_valid_out, 1);
      chk("vp_c_culled", c_culled, 0);
      chk("vp_c_inview", c_iv, 6);
      release_out("vp");

      // Reset asserted mid-divide, then a fresh primitive
      load_a();
      send();
      repeat (10) @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      chk("midrst_valid", a_valid_out, 0);
      chk("midrst_ready", a_ready_out, 0);
      @(negedge clk_in); @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      chk("midrst_ready_back", a_ready_out, 1);
      load_x();
      send();
      wait_out(cyc);
      chk("x_latency", cyc, 117);
      chk_prim("x", -8192, 8192, 0, -4096, -4096, 0, 200, 80, 100, 7, 0);
      release_out("x");

      // Back-to-back with valid_in held: inputs changed while busy must not be captured
      load_x();
      valid_in = 1'b1;
      @(negedge clk_in);
      load_a();
      chk("b2b_busy_ready", a_ready_out, 0);
      wait_out(cyc);
      chk("b2b1_latency", cyc, 117);
      chk_prim("b2b1", -8192, 8192, 0, -4096, -4096, 0, 200, 80, 100, 7, 0);
      repeat (3) @(negedge clk_in);
      chk("b2b_hold_ready", a_ready_out, 0);
      chk("b2b_hold_valid", a_valid_out, 1);
      ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      chk("b2b_xfer_valid", a_valid_out, 0);
      chk("b2b_xfer_ready", a_ready_out, 1);
      @(negedge clk_in);
      valid_in = 1'b0;
      chk("b2b_second_accept", a_ready_out, 0);
      wait_out(cyc);
      chk("b2b2_latency", cyc, 117);
      chk_prim("b2b2", 8192, 0, -8192, 4096, 0, 4096, 200, 100, 80, 7, 0);
      release_out("b2b2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
